// File: rtl/hwreg_responder.sv
// Strobe-handshake register responder exposing the I_STAT/I_MASK interrupt block.
// Optional feature macro HWREG_UNMAPPED_ERR_EN: pulse bus_err when an unmapped access is acked.
module hwreg_responder #(
    parameter int unsigned ACK_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] hw_addr,
    input  logic [31:0] hw_data_i,
    input  logic        hw_wen,
    input  logic        hw_ren,
    output logic [31:0] hw_data_o,
    output logic        hw_ack,
    input  logic [10:0] irq_in,
    output logic        cpu_irq,
    output logic        bus_err
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IRQ_W  = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 16'h1070;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 16'h1074;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ACK_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               capture_c, commit_c;

    logic [ADDR_W-1:0]  addr_q;
    logic [IRQ_W-1:0]   data_q;
    logic               wr_q;
    logic [IRQ_W-1:0]   i_stat, i_mask;
    logic [IRQ_W-1:0]   irq_q;
    logic               irq_armed;
    logic [IRQ_W-1:0]   new_edges_c;
    logic               wr_stat_c, wr_mask_c;
    logic [DATA_W-1:0]  rd_data_c;

    // Upper address and data bits are not decoded.
    logic unused_bits;
    assign unused_bits = ^{hw_addr[31:16], hw_data_i[31:11]};

    // State and latency counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: capture in IDLE, count in BUSY (abort if strobes drop), hold in ACK
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture_c = 1'b0;
        commit_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (hw_wen || hw_ren) begin
                    state_nxt = BUSY;
                    cnt_nxt   = '0;
                    capture_c = 1'b1;
                end
            end
            BUSY: begin
                if (!hw_wen && !hw_ren) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ACK;
                    commit_c  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                if (!hw_wen && !hw_ren) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access capture; write wins when both strobes are high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (capture_c) begin
            addr_q <= hw_addr[ADDR_W-1:0];
            data_q <= hw_data_i[IRQ_W-1:0];
            wr_q   <= hw_wen;
        end
    end

    assign wr_stat_c = commit_c && wr_q && (addr_q == ADDR_STAT);
    assign wr_mask_c = commit_c && wr_q && (addr_q == ADDR_MASK);

    // Edges are ignored on the first cycle after reset so levels already high are not counted.
    assign new_edges_c = irq_armed ? (irq_in & ~irq_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            irq_armed <= 1'b0;
        end else begin
            irq_q     <= irq_in;
            irq_armed <= 1'b1;
        end
    end

    // Interrupt status/mask; a new edge beats a simultaneous write-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_stat  <= '0;
            i_mask  <= '0;
            cpu_irq <= 1'b0;
        end else begin
            if (wr_stat_c) begin
                i_stat <= (i_stat & data_q) | new_edges_c;
            end else begin
                i_stat <= i_stat | new_edges_c;
            end
            if (wr_mask_c) begin
                i_mask <= data_q;
            end
            cpu_irq <= |(i_stat & i_mask);
        end
    end

    always_comb begin
        rd_data_c = '0;
        if (addr_q == ADDR_STAT) begin
            rd_data_c = DATA_W'(i_stat);
        end else if (addr_q == ADDR_MASK) begin
            rd_data_c = DATA_W'(i_mask);
        end
    end

    // Handshake outputs; read data is held for the whole ack phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_ack    <= 1'b0;
            hw_data_o <= '0;
        end else begin
            hw_ack <= (state_nxt == ACK);
            if (commit_c && !wr_q) begin
                hw_data_o <= rd_data_c;
            end else if (state_nxt != ACK) begin
                hw_data_o <= '0;
            end
        end
    end

`ifdef HWREG_UNMAPPED_ERR_EN
    logic unmapped_c;
    assign unmapped_c = (addr_q != ADDR_STAT) && (addr_q != ADDR_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= commit_c && unmapped_c;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule
